// File: rtl/vga_bounce_drawer.sv
// ---------------------------------------------------------------------------
// vga_bounce_drawer
//
// Draws one BOXW x BOXH box in BOX_RGB over a BG_RGB background. The box
// moves STEP pixels on each axis every FRAMEDIV frames and bounces off the
// edges of the active area. The block sits between the VGA timing generator
// and the 4-bit-per-channel DAC pins.
//
// Ports:
//   clk          pixel-domain clock
//   reset        asynchronous, active-high reset
//   isdisplayed  high while (x,y) is inside the active area
//   x, y         current pixel coordinates from the timing generator
//   run          1 = motion enabled; 0 = box frozen and frame divider held
//   recenter     synchronous pulse that returns the box to the centre
//   r, g, b      registered pixel colour (one clock of latency)
//   hit          one-cycle pulse after any move that bounced on either axis
// ---------------------------------------------------------------------------
module vga_bounce_drawer #(
    parameter logic [9:0]  HACTIVE  = 10'd640,
    parameter logic [9:0]  VACTIVE  = 10'd480,
    parameter logic [9:0]  BOXW     = 10'd320,
    parameter logic [9:0]  BOXH     = 10'd240,
    parameter logic [9:0]  STEP     = 10'd4,
    parameter logic [7:0]  FRAMEDIV = 8'd1,
    parameter logic [11:0] BOX_RGB  = 12'hF00,
    parameter logic [11:0] BG_RGB   = 12'h00F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       isdisplayed,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       run,
    input  logic       recenter,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       hit
);

    // Largest legal top-left coordinate on each axis; zero when the box
    // fills the whole axis.
    localparam logic [9:0]  MAX_X      = HACTIVE - BOXW;
    localparam logic [9:0]  MAX_Y      = VACTIVE - BOXH;
    localparam logic [9:0]  START_X    = MAX_X >> 1;
    localparam logic [9:0]  START_Y    = MAX_Y >> 1;
    localparam logic [10:0] STEP_W     = {1'b0, STEP};
    localparam logic [7:0]  LAST_FRAME = FRAMEDIV - 8'd1;

    typedef enum logic {
        DIR_POS,
        DIR_NEG
    } dir_t;

    // Architectural state
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    dir_t        dir_x;
    dir_t        dir_y;
    logic [7:0]  frame_cnt;
    logic        tick_prev;

    // Next-state values
    logic [9:0]  box_x_next;
    logic [9:0]  box_y_next;
    dir_t        dir_x_next;
    dir_t        dir_y_next;
    logic [7:0]  frame_cnt_next;
    logic        hit_next;

    // Candidate per-axis move results
    logic [9:0]  step_x;
    logic [9:0]  step_y;
    dir_t        turn_x;
    dir_t        turn_y;
    logic        bounce_x;
    logic        bounce_y;

    // Frame tick and pixel path
    logic        tick_now;
    logic        tick;
    logic        in_box_x;
    logic        in_box_y;
    logic [11:0] pixel_next;

    // The timing generator parks on (0, VACTIVE) once per frame; that spot
    // may be held for several clocks, so only its rising edge is a tick.
    assign tick_now = (x == 10'd0) && (y == VACTIVE);
    assign tick     = tick_now && !tick_prev;

    // Candidate horizontal move. Sums are widened to 11 bits so pos+STEP
    // never wraps, and an overshoot clamps exactly onto the limit.
    always_comb begin
        step_x   = box_x;
        turn_x   = dir_x;
        bounce_x = 1'b0;
        if (dir_x == DIR_POS) begin
            if (({1'b0, box_x} + STEP_W) >= {1'b0, MAX_X}) begin
                step_x   = MAX_X;
                turn_x   = DIR_NEG;
                bounce_x = 1'b1;
            end else begin
                step_x = box_x + STEP;
            end
        end else begin
            if ({1'b0, box_x} <= STEP_W) begin
                step_x   = 10'd0;
                turn_x   = DIR_POS;
                bounce_x = 1'b1;
            end else begin
                step_x = box_x - STEP;
            end
        end
    end

    // Candidate vertical move, same rules against the vertical limit.
    always_comb begin
        step_y   = box_y;
        turn_y   = dir_y;
        bounce_y = 1'b0;
        if (dir_y == DIR_POS) begin
            if (({1'b0, box_y} + STEP_W) >= {1'b0, MAX_Y}) begin
                step_y   = MAX_Y;
                turn_y   = DIR_NEG;
                bounce_y = 1'b1;
            end else begin
                step_y = box_y + STEP;
            end
        end else begin
            if ({1'b0, box_y} <= STEP_W) begin
                step_y   = 10'd0;
                turn_y   = DIR_POS;
                bounce_y = 1'b1;
            end else begin
                step_y = box_y - STEP;
            end
        end
    end

    // Motion control: recenter wins over a tick; ticks are ignored while
    // run is low, so the frame divider is held as well as the box.
    always_comb begin
        box_x_next     = box_x;
        box_y_next     = box_y;
        dir_x_next     = dir_x;
        dir_y_next     = dir_y;
        frame_cnt_next = frame_cnt;
        hit_next       = 1'b0;
        if (recenter) begin
            box_x_next     = START_X;
            box_y_next     = START_Y;
            dir_x_next     = DIR_POS;
            dir_y_next     = DIR_POS;
            frame_cnt_next = 8'd0;
        end else if (tick && run) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt_next = 8'd0;
                box_x_next     = step_x;
                box_y_next     = step_y;
                dir_x_next     = turn_x;
                dir_y_next     = turn_y;
                hit_next       = bounce_x || bounce_y;
            end else begin
                frame_cnt_next = frame_cnt + 8'd1;
            end
        end
    end

    // Pixel colour uses the box position as it stands this cycle, so a move
    // only becomes visible on the following pixel.
    always_comb begin
        in_box_x = ({1'b0, x} >= {1'b0, box_x}) &&
                   ({1'b0, x} <  ({1'b0, box_x} + {1'b0, BOXW}));
        in_box_y = ({1'b0, y} >= {1'b0, box_y}) &&
                   ({1'b0, y} <  ({1'b0, box_y} + {1'b0, BOXH}));
        if (!isdisplayed) begin
            pixel_next = 12'h000;
        end else if (in_box_x && in_box_y) begin
            pixel_next = BOX_RGB;
        end else begin
            pixel_next = BG_RGB;
        end
    end

    // State and output registers; reset blanks the DAC straight away and
    // re-centres the box so the first tick after release is frame 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_x     <= START_X;
            box_y     <= START_Y;
            dir_x     <= DIR_POS;
            dir_y     <= DIR_POS;
            frame_cnt <= 8'd0;
            tick_prev <= 1'b0;
            hit       <= 1'b0;
            r         <= 4'd0;
            g         <= 4'd0;
            b         <= 4'd0;
        end else begin
            box_x     <= box_x_next;
            box_y     <= box_y_next;
            dir_x     <= dir_x_next;
            dir_y     <= dir_y_next;
            frame_cnt <= frame_cnt_next;
            tick_prev <= tick_now;
            hit       <= hit_next;
            r         <= pixel_next[11:8];
            g         <= pixel_next[7:4];
            b         <= pixel_next[3:0];
        end
    end

endmodule

// File: tb/tb_vga_bounce_drawer.sv
// ---------------------------------------------------------------------------
// tb_vga_bounce_drawer
//
// Drives three instances of vga_bounce_drawer from shared inputs:
//   0: default parameters
//   1: STEP=7, FRAMEDIV=3
//   2: box fills the screen (both axis limits are zero)
// A behavioural model tracks each box's position, direction and frame count
// and predicts the colour and hit outputs one clock ahead.
// ---------------------------------------------------------------------------
module tb_vga_bounce_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       isdisplayed;
    logic [9:0] x;
    logic [9:0] y;
    logic       run;
    logic       recenter;
    logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic       hit0, hit1, hit2;

    int checks = 0;
    int passed = 0;

    // Model configuration and state, one entry per instance
    int bw  [3] = '{320, 320, 640};
    int bh  [3] = '{240, 240, 480};
    int st  [3] = '{4, 7, 4};
    int dv  [3] = '{1, 3, 1};
    int m_x [3];
    int m_y [3];
    int m_dx[3];
    int m_dy[3];
    int m_cnt[3];
    bit m_prev;
    logic [11:0] exp_rgb[3];
    logic        exp_hit[3];

    always #5 clk = ~clk;

    vga_bounce_drawer dut0 (
        .clk(clk), .reset(reset), .isdisplayed(isdisplayed), .x(x), .y(y),
        .run(run), .recenter(recenter), .r(r0), .g(g0), .b(b0), .hit(hit0)
    );

    vga_bounce_drawer #(.STEP(10'd7), .FRAMEDIV(8'd3)) dut1 (
        .clk(clk), .reset(reset), .isdisplayed(isdisplayed), .x(x), .y(y),
        .run(run), .recenter(recenter), .r(r1), .g(g1), .b(b1), .hit(hit1)
    );

    vga_bounce_drawer #(.BOXW(10'd640), .BOXH(10'd480)) dut2 (
        .clk(clk), .reset(reset), .isdisplayed(isdisplayed), .x(x), .y(y),
        .run(run), .recenter(recenter), .r(r2), .g(g2), .b(b2), .hit(hit2)
    );

    function automatic logic [11:0] rgb_of(input int i);
        case (i)
            0:       return {r0, g0, b0};
            1:       return {r1, g1, b1};
            default: return {r2, g2, b2};
        endcase
    endfunction

    function automatic logic hit_of(input int i);
        case (i)
            0:       return hit0;
            1:       return hit1;
            default: return hit2;
        endcase
    endfunction

    // Box returns to the middle of the screen heading right and down.
    task automatic model_center(input int i);
        m_x[i]   = (640 - bw[i]) / 2;
        m_y[i]   = (480 - bh[i]) / 2;
        m_dx[i]  = 1;
        m_dy[i]  = 1;
        m_cnt[i] = 0;
    endtask

    // One axis of a move: overshooting either limit lands on it and turns.
    task automatic axis_move(inout int pos, inout int dir, input int lim,
                             input int stp, output bit bounced);
        bounced = 1'b0;
        if (dir > 0) begin
            if (pos + stp >= lim) begin pos = lim; dir = -1; bounced = 1'b1; end
            else pos = pos + stp;
        end else begin
            if (pos <= stp) begin pos = 0; dir = 1; bounced = 1'b1; end
            else pos = pos - stp;
        end
    endtask

    // Predict this clock's registered outputs, advance the model, then clock.
    task automatic cycle();
        bit tn, tk, bx, by;
        tn = (x == 10'd0) && (y == 10'd480);
        tk = tn && !m_prev;
        for (int i = 0; i < 3; i++) begin
            if (!isdisplayed) exp_rgb[i] = 12'h000;
            else if (int'(x) >= m_x[i] && int'(x) < m_x[i] + bw[i] &&
                     int'(y) >= m_y[i] && int'(y) < m_y[i] + bh[i]) exp_rgb[i] = 12'hF00;
            else exp_rgb[i] = 12'h00F;
            exp_hit[i] = 1'b0;
            if (recenter) begin
                model_center(i);
            end else if (tk && run) begin
                if (m_cnt[i] == dv[i] - 1) begin
                    m_cnt[i] = 0;
                    axis_move(m_x[i], m_dx[i], 640 - bw[i], st[i], bx);
                    axis_move(m_y[i], m_dy[i], 480 - bh[i], st[i], by);
                    exp_hit[i] = bx || by;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        m_prev = tn;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int px, input int py, input logic d);
        x           = 10'(px);
        y           = 10'(py);
        isdisplayed = d;
    endtask

    task automatic do_tick();
        drive(0, 480, 1'b0);
        cycle();
    endtask

    task automatic rand_cycle();
        drive($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)));
        cycle();
    endtask

    task automatic probe(input int px, input int py);
        drive(px, py, 1'b1);
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; recenter = 1'b0;
        drive(200, 200, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rgb_of(i) !== 12'h000) $display("[TB] FAIL reset_rgb%0d: got %h expected 000", i, rgb_of(i));
            else passed++;
            checks++;
            if (hit_of(i) !== 1'b0) $display("[TB] FAIL reset_hit%0d: got %b expected 0", i, hit_of(i));
            else passed++;
        end
        for (int i = 0; i < 3; i++) model_center(i);
        m_prev = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_pixels();
        int px[5] = '{160, 159, 479, 480, 160};
        int py[5] = '{120, 120, 359, 359, 120};
        logic pd[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] ex[5] = '{12'hF00, 12'h00F, 12'hF00, 12'h00F, 12'h000};
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(px[k], py[k], pd[k]);
            cycle();
            checks++;
            if (rgb_of(0) !== ex[k]) $display("[TB] FAIL pixel%0d: got %h expected %h", k, rgb_of(0), ex[k]);
            else passed++;
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rgb_of(i) !== exp_rgb[i]) $display("[TB] FAIL pixel%0d_inst%0d: got %h expected %h", k, i, rgb_of(i), exp_rgb[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_single_move();
        run = 1'b1;
        drive(0, 480, 1'b0);
        repeat (3) begin
            cycle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hit_of(i) !== exp_hit[i]) $display("[TB] FAIL held_tick_hit%0d: got %b expected %b", i, hit_of(i), exp_hit[i]);
                else passed++;
            end
        end
        probe(164, 124);
        checks++;
        if (rgb_of(0) !== 12'hF00) $display("[TB] FAIL move_corner_in: got %h expected F00", rgb_of(0));
        else passed++;
        probe(163, 124);
        checks++;
        if (rgb_of(0) !== 12'h00F) $display("[TB] FAIL move_left_out: got %h expected 00F", rgb_of(0));
        else passed++;
        probe(164, 123);
        checks++;
        if (rgb_of(0) !== 12'h00F) $display("[TB] FAIL move_top_out: got %h expected 00F", rgb_of(0));
        else passed++;
        checks++;
        if (rgb_of(1) !== exp_rgb[1]) $display("[TB] FAIL move_inst1: got %h expected %h", rgb_of(1), exp_rgb[1]);
        else passed++;
    endtask

    task automatic test_bounce();
        for (int t = 2; t <= 41; t++) begin
            do_tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hit_of(i) !== exp_hit[i]) $display("[TB] FAIL bounce_hit%0d_t%0d: got %b expected %b", i, t, hit_of(i), exp_hit[i]);
                else passed++;
            end
            if (t == 30 || t == 40) begin
                checks++;
                if (hit0 !== 1'b1) $display("[TB] FAIL edge_hit_t%0d: got %b expected 1", t, hit0);
                else passed++;
            end
            rand_cycle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rgb_of(i) !== exp_rgb[i]) $display("[TB] FAIL bounce_rgb%0d_t%0d: got %h expected %h", i, t, rgb_of(i), exp_rgb[i]);
                else passed++;
                checks++;
                if (hit_of(i) !== 1'b0) $display("[TB] FAIL hit_width%0d_t%0d: got %b expected 0", i, t, hit_of(i));
                else passed++;
            end
        end
        probe(316, 196);
        checks++;
        if (rgb_of(0) !== 12'hF00) $display("[TB] FAIL after_bounce_in: got %h expected F00", rgb_of(0));
        else passed++;
        probe(315, 196);
        checks++;
        if (rgb_of(0) !== 12'h00F) $display("[TB] FAIL after_bounce_out: got %h expected 00F", rgb_of(0));
        else passed++;
    endtask

    task automatic test_step7();
        drive(5, 5, 1'b1);
        recenter = 1'b1;
        cycle();
        recenter = 1'b0;
        for (int t = 1; t <= 72; t++) begin
            do_tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hit_of(i) !== exp_hit[i]) $display("[TB] FAIL s7_hit%0d_t%0d: got %b expected %b", i, t, hit_of(i), exp_hit[i]);
                else passed++;
            end
            if (t == 69) begin
                checks++;
                if (hit1 !== 1'b1) $display("[TB] FAIL s7_clamp_hit: got %b expected 1", hit1);
                else passed++;
                probe(320, 205);
                checks++;
                if (rgb_of(1) !== 12'hF00) $display("[TB] FAIL s7_clamp_in: got %h expected F00", rgb_of(1));
                else passed++;
                probe(319, 205);
                checks++;
                if (rgb_of(1) !== 12'h00F) $display("[TB] FAIL s7_clamp_out: got %h expected 00F", rgb_of(1));
                else passed++;
            end
            rand_cycle();
            checks++;
            if (rgb_of(1) !== exp_rgb[1]) $display("[TB] FAIL s7_rgb_t%0d: got %h expected %h", t, rgb_of(1), exp_rgb[1]);
            else passed++;
        end
        probe(313, 198);
        checks++;
        if (rgb_of(1) !== 12'hF00) $display("[TB] FAIL s7_back_in: got %h expected F00", rgb_of(1));
        else passed++;
        probe(312, 198);
        checks++;
        if (rgb_of(1) !== 12'h00F) $display("[TB] FAIL s7_back_out: got %h expected 00F", rgb_of(1));
        else passed++;
    endtask

    task automatic test_framediv();
        drive(5, 5, 1'b1);
        recenter = 1'b1;
        cycle();
        recenter = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            run = (t != 4);
            do_tick();
            run = 1'b1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hit_of(i) !== exp_hit[i]) $display("[TB] FAIL div_hit%0d_t%0d: got %b expected %b", i, t, hit_of(i), exp_hit[i]);
                else passed++;
            end
            if (t == 3 || t == 6) begin
                probe(167, 127);
                checks++;
                if (rgb_of(1) !== 12'hF00) $display("[TB] FAIL div_in_t%0d: got %h expected F00", t, rgb_of(1));
                else passed++;
                probe(166, 127);
                checks++;
                if (rgb_of(1) !== 12'h00F) $display("[TB] FAIL div_out_t%0d: got %h expected 00F", t, rgb_of(1));
                else passed++;
            end
            if (t == 7) begin
                probe(174, 134);
                checks++;
                if (rgb_of(1) !== 12'hF00) $display("[TB] FAIL div_shift_in: got %h expected F00", rgb_of(1));
                else passed++;
                probe(173, 134);
                checks++;
                if (rgb_of(1) !== 12'h00F) $display("[TB] FAIL div_shift_out: got %h expected 00F", rgb_of(1));
                else passed++;
            end
            rand_cycle();
        end
    endtask

    task automatic test_recenter_tick();
        repeat (3) begin do_tick(); rand_cycle(); end
        drive(0, 480, 1'b0);
        recenter = 1'b1;
        cycle();
        recenter = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hit_of(i) !== 1'b0) $display("[TB] FAIL recenter_hit%0d: got %b expected 0", i, hit_of(i));
            else passed++;
        end
        probe(160, 120);
        checks++;
        if (rgb_of(0) !== 12'hF00) $display("[TB] FAIL recenter_in: got %h expected F00", rgb_of(0));
        else passed++;
        checks++;
        if (rgb_of(1) !== 12'hF00) $display("[TB] FAIL recenter_in1: got %h expected F00", rgb_of(1));
        else passed++;
        probe(159, 120);
        checks++;
        if (rgb_of(0) !== 12'h00F) $display("[TB] FAIL recenter_left: got %h expected 00F", rgb_of(0));
        else passed++;
        probe(160, 119);
        checks++;
        if (rgb_of(0) !== 12'h00F) $display("[TB] FAIL recenter_top: got %h expected 00F", rgb_of(0));
        else passed++;
    endtask

    task automatic test_reset_midline();
        do_tick();
        rand_cycle();
        probe(200, 200);
        checks++;
        if (rgb_of(0) !== exp_rgb[0]) $display("[TB] FAIL pre_reset_rgb: got %h expected %h", rgb_of(0), exp_rgb[0]);
        else passed++;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rgb_of(i) !== 12'h000) $display("[TB] FAIL async_rgb%0d: got %h expected 000", i, rgb_of(i));
            else passed++;
        end
        for (int i = 0; i < 3; i++) model_center(i);
        m_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hit_of(i) !== exp_hit[i]) $display("[TB] FAIL post_reset_hit%0d_t%0d: got %b expected %b", i, t, hit_of(i), exp_hit[i]);
                else passed++;
            end
            if (t == 1) begin
                probe(164, 124);
                checks++;
                if (rgb_of(0) !== 12'hF00) $display("[TB] FAIL post_reset_move: got %h expected F00", rgb_of(0));
                else passed++;
            end
            if (t == 3) begin
                probe(167, 127);
                checks++;
                if (rgb_of(1) !== 12'hF00) $display("[TB] FAIL post_reset_frame3_in: got %h expected F00", rgb_of(1));
                else passed++;
                probe(166, 127);
                checks++;
                if (rgb_of(1) !== 12'h00F) $display("[TB] FAIL post_reset_frame3_out: got %h expected 00F", rgb_of(1));
                else passed++;
            end
            rand_cycle();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            run      = ($urandom_range(0, 7) != 0);
            recenter = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) drive(0, 480, 1'($urandom_range(0, 1)));
            else drive($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)));
            cycle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rgb_of(i) !== exp_rgb[i]) $display("[TB] FAIL rand_rgb%0d_n%0d: got %h expected %h", i, n, rgb_of(i), exp_rgb[i]);
                else passed++;
                checks++;
                if (hit_of(i) !== exp_hit[i]) $display("[TB] FAIL rand_hit%0d_n%0d: got %b expected %b", i, n, hit_of(i), exp_hit[i]);
                else passed++;
            end
        end
        recenter = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_single_move();
        test_bounce();
        test_step7();
        test_framediv();
        test_recenter_tick();
        test_reset_midline();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
